alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 iCLK  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 iRSTn  input  1  synchronous active-low reset, sampled on the iCLK rising edge.
REQ-004 iA  input  4  operand A, unsigned.
REQ-005 iB  input  4  operand B, unsigned.
REQ-006 iINST  input  4  operation select, 0x0-0xF; all 16 codes are defined.
REQ-007 oRESULT  output  8  registered result.

Function
REQ-008 oRESULT SHALL be registered; on each rising edge with iRSTn high, it SHALL load f(iA, iB, iINST) from the values sampled at that edge (latency 1 cycle, no handshake, new operation accepted every cycle).
REQ-009 Operands SHALL be zero-extended to 8 bits before every arithmetic operation; results SHALL be truncated to 8 bits.
REQ-010 0x0 ADD: A+B (range 0x00-0x1E).
REQ-011 0x1 SUB: (A-B) mod 256, so A<B yields the 8-bit two's-complement negative (e.g., 2-11 = 0xF7).
REQ-012 0x2 MUL: A*B (max 0xE1).
REQ-013 0x3 DIV: A/B quotient; B=0 SHALL give 0xFF.
REQ-014 0x4 MOD: A%B remainder; B=0 SHALL give {4'h0, A}.
REQ-015 0x5 AND; 0x6 OR; 0x7 XOR -- bitwise on 4 bits; upper nibble 0.
REQ-016 0x8 NOT: {4'h0, ~A}.
REQ-017 0x9 SHL: ({4'h0,A} << B[2:0]) truncated to 8 bits.
REQ-018 0xA SHR: {4'h0, A >> B[1:0]}, logical.
REQ-019 0xB ROL: {4'h0, A rotated left within 4 bits by B[1:0]}.
REQ-020 0xC CMP: 0x01 if A>B, 0x00 if A==B, 0xFF if A<B.
REQ-021 0xD MAX: {4'h0, max(A,B)}; 0xE MIN: {4'h0, min(A,B)}.
REQ-022 0xF CAT: {A, B}.
REQ-023 The next-state logic SHALL be purely combinational from iA, iB, and iINST; no other internal state SHALL exist.
REQ-024 Changing iINST from 0xF to 0x0 SHALL need no special handling; the result SHALL follow the new code on the next edge.

Reset
REQ-025 When iRSTn is low at a rising edge, oRESULT SHALL become 0x00 at that edge, regardless of the inputs.
REQ-026 Reset SHALL take priority over any operation in the same cycle.
REQ-027 Asserting iRSTn in mid-stream SHALL discard the in-flight result.
REQ-028 After iRSTn is released, the first edge SHALL load the current operation's result.
REQ-029 oRESULT SHALL NOT respond to iRSTn between clock edges.

Configuration
REQ-030 Macro ALU_DIV_EN: when defined, codes 0x3 and 0x4 SHALL behave as in REQ-013 and REQ-014.
REQ-031 When ALU_DIV_EN is undefined, codes 0x3 and 0x4 SHALL produce 0x00 and the design SHALL contain no divider logic.
REQ-032 All other codes SHALL be unaffected by ALU_DIV_EN.

Verification
REQ-033 Reset: iRSTn=0 for 2 edges with A=0xB, B=0x2, INST=0xF -> oRESULT=0x00; after release, the next edge -> 0xB2.
REQ-034 Sweep: A=0xB, B=0x2, INST stepping 0x0..0xF, one per 100 ns, then wrapping to 0x0 -> each result one edge later: 0D,09,16,05,01,02,0B,09,04,2C,02,0E,01,0B,02,B2, then 0D after the wrap (with ALU_DIV_EN defined).
REQ-035 Divide by zero: A=0x7, B=0x0 -> INST 0x3 gives 0xFF, INST 0x4 gives 0x07; without ALU_DIV_EN both give 0x00.
REQ-036 Arithmetic extremes: A=0xF, B=0xF -> ADD 0x1E, MUL 0xE1, CMP 0x00, SHL (shift 7) 0x80; A=0x2, B=0xB -> SUB 0xF7, CMP 0xFF.
REQ-037 Back-to-back: change iINST every cycle for 16 random vectors -> each oRESULT matches a reference model with exactly 1-cycle lag.
REQ-038 Mid-stream reset: iRSTn pulsed low for 1 cycle during REQ-037 -> oRESULT=0x00 for exactly that cycle, then resumes matching the model.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - 4-bit operand ALU with a registered 8-bit result
//
// Purpose:
//   Picks one of 16 operations on two unsigned 4-bit operands through iINST.
//   The result is registered, so it appears one cycle after the inputs are
//   sampled. A new operation can start every cycle and there is no handshake.
//   The only state in the block is the result register.
//
// Build option:
//   ALU_DIV_EN - when defined, code 0x3 (DIV) and code 0x4 (MOD) compute the
//                quotient and the remainder. When undefined, both codes give
//                0x00 and no divider is built.
//
// Ports:
//   iCLK     in   1  clock; all state changes on the rising edge
//   iRSTn    in   1  synchronous active-low reset; clears oRESULT to 0x00
//   iA       in   4  operand A, unsigned
//   iB       in   4  operand B, unsigned
//   iINST    in   4  operation select:
//                    0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR,
//                    8 NOT, 9 SHL, A SHR, B ROL, C CMP, D MAX, E MIN, F CAT
//   oRESULT  out  8  registered result

module alu (
  input  logic       iCLK,
  input  logic       iRSTn,
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic [3:0] iINST,
  output logic [7:0] oRESULT
);

  // Zero-extend both operands, so every arithmetic result is naturally 8 bits wide.
  logic [7:0] aExt;
  logic [7:0] bExt;
  logic [7:0] rolPair;
  logic [7:0] nextResult;

  assign aExt = {4'h0, iA};
  assign bExt = {4'h0, iB};

  // Two copies of A side by side. After the shift, the upper nibble holds A
  // rotated left by the shift amount.
  assign rolPair = {iA, iA} << iB[1:0];

  always_comb begin
    nextResult = 8'h00;
    case (iINST)
      4'h0: nextResult = aExt + bExt;
      4'h1: nextResult = aExt - bExt;  // wraps mod 256, so A<B gives a two's-complement negative
      4'h2: nextResult = aExt * bExt;
`ifdef ALU_DIV_EN
      4'h3: nextResult = (iB == 4'h0) ? 8'hFF : (aExt / bExt);
      4'h4: nextResult = (iB == 4'h0) ? aExt  : (aExt % bExt);
`else
      4'h3: nextResult = 8'h00;
      4'h4: nextResult = 8'h00;
`endif
      4'h5: nextResult = {4'h0, iA & iB};
      4'h6: nextResult = {4'h0, iA | iB};
      4'h7: nextResult = {4'h0, iA ^ iB};
      4'h8: nextResult = {4'h0, ~iA};
      4'h9: nextResult = aExt << iB[2:0];
      4'hA: nextResult = {4'h0, iA >> iB[1:0]};
      4'hB: nextResult = {4'h0, rolPair[7:4]};
      4'hC: begin
        if (iA > iB) begin
          nextResult = 8'h01;
        end else if (iA == iB) begin
          nextResult = 8'h00;
        end else begin
          nextResult = 8'hFF;
        end
      end
      4'hD: nextResult = (iA >= iB) ? aExt : bExt;
      4'hE: nextResult = (iA <= iB) ? aExt : bExt;
      4'hF: nextResult = {iA, iB};
    endcase
  end

  // Reset is checked only at the clock edge, and it overrides the operation
  // sampled at that edge.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      oRESULT <= 8'h00;
    end else begin
      oRESULT <= nextResult;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu

module tb_alu;

  logic       iCLK;
  logic       iRSTn;
  logic [3:0] iA;
  logic [3:0] iB;
  logic [3:0] iINST;
  logic [7:0] oRESULT;

  int total;
  int bad;

  logic [7:0] expRes;
  logic       expValid;

  alu dut (
    .iCLK    (iCLK),
    .iRSTn   (iRSTn),
    .iA      (iA),
    .iB      (iB),
    .iINST   (iINST),
    .oRESULT (oRESULT)
  );

  initial iCLK = 1'b0;
  always #50 iCLK = ~iCLK;

  function automatic logic [7:0] refAlu(input int a, input int b, input int inst);
    int r;
    r = 0;
    case (inst)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
`ifdef ALU_DIV_EN
      3:  r = (b == 0) ? 255 : a / b;
      4:  r = (b == 0) ? a : a % b;
`else
      3:  r = 0;
      4:  r = 0;
`endif
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = 15 - a;
      9:  r = a * (1 << (b % 8));
      10: r = a / (1 << (b % 4));
      11: r = ((a * (1 << (b % 4))) % 16) + (a / (1 << (4 - (b % 4)))) % 16;
      12: r = (a > b) ? 1 : ((a == b) ? 0 : 255);
      13: r = (a > b) ? a : b;
      14: r = (a < b) ? a : b;
      15: r = a * 16 + b;
      default: r = 0;
    endcase
    r = r & 255;
    return r[7:0];
  endfunction

  // The reference register loads the value that oRESULT must take at each edge.
  always @(posedge iCLK) begin
    expRes   <= (!iRSTn) ? 8'h00 : refAlu(int'(iA), int'(iB), int'(iINST));
    expValid <= 1'b1;
  end

  always @(negedge iCLK) begin
    if (expValid === 1'b1) begin
      total++;
      if (oRESULT !== expRes) begin
        bad++;
        $display("FAIL model t=%0t got=%02h want=%02h", $time, oRESULT, expRes);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] want);
    total++;
    if (oRESULT !== want) begin
      bad++;
      $display("FAIL %s got=%02h want=%02h", name, oRESULT, want);
    end
  endtask

  // Drives the inputs, waits for the next rising edge, then lets the output settle for 1 time unit.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] inst);
    iA = a;
    iB = b;
    iINST = inst;
    @(posedge iCLK);
    #1;
  endtask

  logic [7:0] sweepExp [16];

  initial begin
    total    = 0;
    bad      = 0;
    expValid = 1'b0;
    iRSTn    = 1'b0;
    iA       = 4'hB;
    iB       = 4'h2;
    iINST    = 4'hF;

    // Model pins: results written out by hand.
    total++; if (refAlu(2, 11, 1) !== 8'hF7) begin bad++; $display("FAIL pin_sub got=%02h want=F7", refAlu(2, 11, 1)); end
    total++; if (refAlu(11, 2, 11) !== 8'h0E) begin bad++; $display("FAIL pin_rol got=%02h want=0E", refAlu(11, 2, 11)); end
    total++; if (refAlu(15, 15, 9) !== 8'h80) begin bad++; $display("FAIL pin_shl got=%02h want=80", refAlu(15, 15, 9)); end

    // Reset held low for two edges with CAT selected.
    @(posedge iCLK); #1; check("rst_edge1", 8'h00);
    @(posedge iCLK); #1; check("rst_edge2", 8'h00);
    iRSTn = 1'b1;
    step(4'hB, 4'h2, 4'hF); check("rst_release", 8'hB2);

    // Reset going low between edges must not change the output.
    #20 iRSTn = 1'b0;
    #10 check("rst_async_ignored", 8'hB2);
    @(posedge iCLK); #1; check("rst_at_edge", 8'h00);
    iRSTn = 1'b1;

    // Step through all 16 codes, then wrap back to 0x0.
    sweepExp = '{8'h0D, 8'h09, 8'h16, 8'h05, 8'h01, 8'h02, 8'h0B, 8'h09,
                 8'h04, 8'h2C, 8'h02, 8'h0E, 8'h01, 8'h0B, 8'h02, 8'hB2};
`ifndef ALU_DIV_EN
    sweepExp[3] = 8'h00;
    sweepExp[4] = 8'h00;
`endif
    for (int i = 0; i < 16; i++) begin
      step(4'hB, 4'h2, 4'(i));
      check($sformatf("sweep_%0h", i), sweepExp[i]);
    end
    step(4'hB, 4'h2, 4'h0); check("sweep_wrap", 8'h0D);

    // Divide by zero.
`ifdef ALU_DIV_EN
    step(4'h7, 4'h0, 4'h3); check("div0", 8'hFF);
    step(4'h7, 4'h0, 4'h4); check("mod0", 8'h07);
`else
    step(4'h7, 4'h0, 4'h3); check("div0", 8'h00);
    step(4'h7, 4'h0, 4'h4); check("mod0", 8'h00);
`endif

    // Arithmetic extremes.
    step(4'hF, 4'hF, 4'h0); check("add_ff", 8'h1E);
    step(4'hF, 4'hF, 4'h2); check("mul_ff", 8'hE1);
    step(4'hF, 4'hF, 4'hC); check("cmp_eq", 8'h00);
    step(4'hF, 4'hF, 4'h9); check("shl7", 8'h80);
    step(4'h2, 4'hB, 4'h1); check("sub_neg", 8'hF7);
    step(4'h2, 4'hB, 4'hC); check("cmp_lt", 8'hFF);

    // 16 random back-to-back vectors, with reset pulsed for one cycle at vector 8.
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        iRSTn = 1'b0;
        step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        check("midstream_rst", 8'h00);
        iRSTn = 1'b1;
      end else begin
        step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      end
    end

    // A longer random run, checked against the model.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    @(negedge iCLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
